// File: rtl/trng_pkg.sv
// Shared types and default parameter values for the TRNG controller.
package trng_pkg;

  localparam int SAMPLE_DIV_DEF = 16;
  localparam int RPT_LIMIT_DEF  = 32;
  localparam int WIDTH_DEF      = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2,
    ST_FAULT   = 2'd3
  } state_e;

  // Increment that sticks at the top of an 8-bit range.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/trng_ctrl_if.sv
// Word output channel of the TRNG controller.
// A word moves on a rising edge where valid_o and ready_i are both high;
// once valid_o rises it stays high with data_o stable until that edge, and
// ready_i has no effect while valid_o is low.
interface trng_ctrl_if
  import trng_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic [WIDTH-1:0] data_o;
  logic             valid_o;
  logic             ready_i;

  modport master (output data_o, output valid_o, input ready_i);
  modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: pairs consecutive samples, emits one bit for an
// unequal pair (the first sample of the pair is the bit), drops equal pairs.
module trng_vn_debias (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic tick_i,
  input  logic sample_i,
  output logic accept_o,
  output logic bit_o
);

  logic phase_q, phase_d;
  logic a_q, a_d;

  // Pair phase and first-of-pair sample registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      a_q     <= 1'b0;
    end else begin
      phase_q <= phase_d;
      a_q     <= a_d;
    end
  end

  // Toggle phase on every tick; capture the first sample of each pair.
  always_comb begin
    phase_d = phase_q;
    a_d     = a_q;
    if (clear_i) begin
      phase_d = 1'b0;
    end else if (tick_i) begin
      phase_d = ~phase_q;
      if (!phase_q) a_d = sample_i;
    end
  end

  assign accept_o = tick_i & phase_q & (a_q ^ sample_i);
  assign bit_o    = a_q;

endmodule

// File: rtl/trng_ctrl.sv
// TRNG controller: synchronizes the raw entropy bit, samples it on a divided
// tick, debiases it, runs a repetition health test and assembles words.
module trng_ctrl
  import trng_pkg::*;
#(
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int RPT_LIMIT  = RPT_LIMIT_DEF,
  parameter int WIDTH      = WIDTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        raw_in,
  trng_ctrl_if.master bus,
  output logic        fault_o,
  output logic        busy_o,
  output state_e      dbg_state_o
);

  localparam int         CW      = $clog2(WIDTH + 1);
  localparam logic [7:0] DIV_MAX = 8'(SAMPLE_DIV - 1);
  localparam logic [7:0] RPT_MAX = 8'(RPT_LIMIT);

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [7:0]       div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [7:0]       rpt_q, rpt_d;
  logic             prev_q, prev_d;

  logic             tick, accept, vn_bit, debias_clear;
  logic [7:0]       rpt_next;
  logic             rpt_hit, word_done;
  logic [WIDTH-1:0] sr_shift;

  // Two-flop synchronizer for the asynchronous entropy source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  assign tick         = (state_q == ST_COLLECT) && en && (div_q == DIV_MAX);
  assign debias_clear = (state_q != ST_COLLECT);

  trng_vn_debias u_debias (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (debias_clear),
    .tick_i   (tick),
    .sample_i (sync2_q),
    .accept_o (accept),
    .bit_o    (vn_bit)
  );

  // A run restarts at 1 on a change; the first tick after IDLE also lands on
  // 1 because the count starts at zero. An accepted pair always differs, so
  // it resets the run and cannot coincide with a health fault for limits >= 2.
  assign rpt_next  = (sync2_q != prev_q) ? 8'd1 : sat_inc8(rpt_q);
  assign rpt_hit   = tick && (rpt_next >= RPT_MAX);
  assign word_done = accept && (cnt_q == CW'(WIDTH - 1));
  assign sr_shift  = {vn_bit, sr_q[WIDTH-1:1]};

  // Datapath registers: divider, bit counter, shift register, word, health.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      cnt_q  <= '0;
      sr_q   <= '0;
      data_q <= '0;
      rpt_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      sr_q   <= sr_d;
      data_q <= data_d;
      rpt_q  <= rpt_d;
      prev_q <= prev_d;
    end
  end

  // Datapath next values; the word is only published when no fault fires.
  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    sr_d   = sr_q;
    data_d = data_q;
    rpt_d  = rpt_q;
    prev_d = prev_q;
    case (state_q)
      ST_IDLE: begin
        div_d  = '0;
        cnt_d  = '0;
        sr_d   = '0;
        rpt_d  = '0;
        prev_d = 1'b0;
      end
      ST_COLLECT: begin
        if (!en) begin
          div_d = '0;
          cnt_d = '0;
        end else begin
          div_d = (div_q == DIV_MAX) ? 8'd0 : div_q + 8'd1;
          if (tick) begin
            rpt_d  = rpt_next;
            prev_d = sync2_q;
          end
          if (accept) begin
            sr_d = sr_shift;
            if (word_done) begin
              cnt_d = '0;
              if (!rpt_hit) data_d = sr_shift;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
      ST_HOLD: begin
        div_d = '0;
        cnt_d = '0;
      end
      default: ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; fault outranks a completed word.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (en) state_d = ST_COLLECT;
      ST_COLLECT: begin
        if (!en)            state_d = ST_IDLE;
        else if (rpt_hit)   state_d = ST_FAULT;
        else if (word_done) state_d = ST_HOLD;
      end
      ST_HOLD:    if (bus.ready_i) state_d = en ? ST_COLLECT : ST_IDLE;
      ST_FAULT:   if (!en) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    bus.valid_o = (state_q == ST_HOLD);
    fault_o     = (state_q == ST_FAULT);
    busy_o      = (state_q != ST_IDLE);
    dbg_state_o = state_q;
  end

  assign bus.data_o = data_q;

endmodule

// File: tb/tb_trng_ctrl.sv
// Bench for trng_ctrl: tick-aligned raw stimulus, word-level reference model,
// expected-word queue drained by an independent output monitor.
module tb_trng_ctrl;
  import trng_pkg::*;

  localparam int SD  = 4;
  localparam int RPT = 32;
  localparam int W   = 8;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   en = 1'b0;
  logic   raw_in = 1'b0;
  logic   fault_o, busy_o;
  state_e dbg_state;

  trng_ctrl_if #(.WIDTH(W)) bus ();

  trng_ctrl #(.SAMPLE_DIV(SD), .RPT_LIMIT(RPT), .WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .raw_in      (raw_in),
    .bus         (bus),
    .fault_o     (fault_o),
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state)
  );

  // Clock and counters.
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: samples in, whole words out.
  bit           m_have_a;
  bit           m_a;
  int           m_nbits;
  logic [W-1:0] m_word;
  int           m_rpt;
  bit           m_prev;

  task automatic model_clear();
    m_have_a = 0; m_a = 0; m_nbits = 0; m_word = '0; m_rpt = 0; m_prev = 0;
  endtask

  // st: 0 = nothing, 1 = word complete, 2 = health fault
  task automatic model_sample(input bit s, output int st);
    st = 0;
    if (m_rpt == 0 || s != m_prev) m_rpt = 1;
    else if (m_rpt < 255) m_rpt++;
    m_prev = s;
    if (!m_have_a) begin
      m_a = s;
      m_have_a = 1;
    end else begin
      m_have_a = 0;
      if (m_a != s) begin
        m_word[m_nbits] = m_a;
        m_nbits++;
      end
    end
    if (m_rpt >= RPT) begin
      st = 2;
    end else if (m_nbits == W) begin
      exp_q.push_back(m_word);
      m_nbits = 0; m_word = '0; m_have_a = 0;
      st = 1;
    end
  endtask

  // Monitor: every accepted word must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && bus.valid_o && bus.ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_word: data_o=%0h offered with nothing expected", bus.data_o);
        end else begin
          check("word", bus.data_o, exp_q.pop_front());
        end
      end
    end
  end

  // Driver tasks. Each sample window starts at the negedge after the edge
  // that zeroes the divider, so the synchronized value is settled at the tick.
  task automatic feed(input bit s, output int st);
    @(negedge clk);
    raw_in = s;
    repeat (SD) @(posedge clk);
    model_sample(s, st);
    #1;
    if (st == 2) begin
      check("fault_after_limit", fault_o, 1);
      check("valid_in_fault", bus.valid_o, 0);
    end else begin
      check("fault_low", fault_o, 0);
    end
  endtask

  task automatic feed_seq(input bit seq[$], output int st);
    st = 0;
    foreach (seq[i]) begin
      if (st == 0) feed(seq[i], st);
    end
  endtask

  task automatic start_collect();
    @(negedge clk);
    en = 1;
    @(posedge clk);
    #1;
    check("busy_collect", busy_o, 1);
    model_clear();
  endtask

  task automatic go_idle(input string tag);
    @(negedge clk);
    en = 0;
    @(posedge clk);
    #1;
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_fault"}, fault_o, 0);
    check({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  task automatic finish_word(input int stall, input bit drop_en);
    logic [W-1:0] snap;
    @(negedge clk);
    if (drop_en) en = 0;
    bus.ready_i = (stall == 0);
    snap = bus.data_o;
    check("valid_hold", bus.valid_o, 1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      raw_in = 1'($urandom_range(0, 1));
      check("stall_valid", bus.valid_o, 1);
      check("stall_data", bus.data_o, snap);
      check("stall_busy", busy_o, 1);
    end
    bus.ready_i = 1;
    @(posedge clk);
    #1;
    check("valid_after_xfer", bus.valid_o, 0);
    check("busy_after_xfer", busy_o, drop_en ? 0 : 1);
  endtask

  task automatic collect_word(input int stall, input bit drop_en);
    int st = 0;
    int n = 0;
    while (st == 0 && n < 400) begin
      feed(1'($urandom_range(0, 1)), st);
      n++;
    end
    if (st == 0) begin
      n_checks++;
      $display("FAIL collect_timeout: no word after %0d samples", n);
    end else if (st == 1) begin
      finish_word(stall, drop_en);
    end else begin
      go_idle("rand_fault_exit");
      start_collect();
    end
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check({tag, "_data"}, bus.data_o, 0);
    check({tag, "_valid"}, bus.valid_o, 0);
    check({tag, "_fault"}, fault_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    @(negedge clk);
    en = 0;
    bus.ready_i = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    model_clear();
  endtask

  // Stimulus.
  initial begin
    bit seq[$];
    int st;
    bus.ready_i = 1;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", bus.data_o, 0);
    check("rst_valid", bus.valid_o, 0);
    check("rst_fault", fault_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 0;

    // Directed pattern 0,1,1,0 repeated.
    for (int i = 0; i < 16; i++) seq.push_back(((i % 4) == 1) || ((i % 4) == 2));
    start_collect();
    feed_seq(seq, st);
    if (st == 1) finish_word(0, 0);

    // Random words, back-to-back and with stalls (one of 50 cycles).
    repeat (4) collect_word(0, 0);
    collect_word(50, 0);
    collect_word($urandom_range(1, 8), 0);

    // en dropped while holding a word: held until transfer, then IDLE.
    collect_word(5, 1);
    repeat (10) @(posedge clk);

    // en dropped at bit 5: partial word discarded, next word from scratch.
    start_collect();
    st = 0;
    for (int i = 0; i < 200 && m_nbits < 5 && st == 0; i++) feed(1'($urandom_range(0, 1)), st);
    go_idle("drop_bit5");
    model_clear();
    start_collect();
    collect_word(0, 0);

    // Reset mid-collection.
    for (int i = 0; i < 5; i++) feed(1'($urandom_range(0, 1)), st);
    pulse_reset("rst_collect");
    start_collect();
    collect_word(0, 0);

    // Reset while a word is held: the word is lost.
    st = 0;
    for (int i = 0; i < 400 && st == 0; i++) feed(1'($urandom_range(0, 1)), st);
    @(negedge clk);
    bus.ready_i = 0;
    repeat (3) @(posedge clk);
    pulse_reset("rst_hold");
    if (st == 1) void'(exp_q.pop_back());
    repeat (10) @(posedge clk);
    start_collect();
    collect_word(0, 0);

    // Constant 1: only equal pairs, fault exactly one cycle after tick RPT.
    go_idle("pre_fault1");
    start_collect();
    for (int i = 0; i < RPT; i++) feed(1'b1, st);
    repeat (20) begin
      @(negedge clk);
      raw_in = 1'($urandom_range(0, 1));
    end
    check("fault_stays", fault_o, 1);
    check("fault_busy", busy_o, 1);
    check("fault_no_valid", bus.valid_o, 0);
    go_idle("fault_exit");
    start_collect();
    collect_word(0, 0);

    // Constant 0 into fault, then reset out of FAULT.
    go_idle("pre_fault0");
    start_collect();
    for (int i = 0; i < RPT; i++) feed(1'b0, st);
    pulse_reset("rst_fault");
    start_collect();
    collect_word(0, 0);

    // Random tail.
    repeat (3) collect_word($urandom_range(0, 3), 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
